ac97_user_ctrl: RTL and testbench

- Upstream front-panel stage for the AC'97 command controller. It produces the `volume[4:0]` and `source[2:0]` inputs that the command controller turns into codec register writes.
- Inputs are three raw Atlys push-buttons: volume up, volume down, record-source select.
- Each button is synchronised and debounced, and turned into press events.
- Press events drive a saturating volume register and a wrapping source register.
- A one-cycle change strobe is emitted whenever either register actually changes.

---
 rtl/ac97_user_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ac97_user_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac97_user_ctrl.sv
// Front-panel controller: debounces three push-buttons into press events that
// drive a saturating volume and a wrapping record source. Optional: AUTO_REPEAT_EN.
module ac97_user_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int VOL_RESET       = 20,
  parameter int SRC_RESET       = 0,
  parameter int SRC_MAX         = 4,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       ac97_ready,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_src,
  output logic [4:0] volume,
  output logic [2:0] source,
  output logic       changed
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Bit 0 = up, bit 1 = down, bit 2 = source select.
  logic [2:0]       btn_raw;
  logic [2:0]       sync_q1;
  logic [2:0]       sync_q2;
  logic [2:0]       deb;
  logic [2:0]       deb_q;
  logic [2:0]       press;
  logic [DEB_W-1:0] deb_cnt [3];

  assign btn_raw = {btn_src, btn_down, btn_up};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      deb     <= '0;
      deb_q   <= '0;
      // NOTE: the counter array is small and plain flops, so it is reset with
      // the rest of the state; no RAM inference is expected here.
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
      deb_q   <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync_q2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]     <= ~deb[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Events are dropped, never queued, while the codec is not ready.
  assign press = deb & ~deb_q & {3{ac97_ready}};

  logic up_ev;
  logic dn_ev;
  logic src_ev;

`ifdef AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_e;

  logic [1:0] rpt_ev;

  for (genvar g = 0; g < 2; g++) begin : g_rpt
    rpt_state_e       state_q;
    rpt_state_e       state_d;
    logic [RPT_W-1:0] cnt_q;
    logic [RPT_W-1:0] cnt_d;
    logic             ev;

    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
        state_q <= RPT_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // NOTE: every output of this block is defaulted first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ev      = 1'b0;
      if (!deb[g] || !ac97_ready) begin
        state_d = RPT_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          RPT_IDLE: begin
            if (press[g]) begin
              state_d = RPT_DELAY;
              cnt_d   = '0;
            end
          end
          RPT_DELAY: begin
            if (cnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
              ev      = 1'b1;
              state_d = RPT_REPEAT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          RPT_REPEAT: begin
            if (cnt_q == RPT_W'(REPEAT_RATE - 1)) begin
              ev    = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = RPT_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    assign rpt_ev[g] = ev;
  end

  assign up_ev = press[0] | rpt_ev[0];
  assign dn_ev = press[1] | rpt_ev[1];
`else
  assign up_ev = press[0];
  assign dn_ev = press[1];
`endif

  assign src_ev = press[2];

  logic [4:0] vol_d;
  logic [2:0] src_d;

  always_comb begin
    vol_d = volume;
    src_d = source;
    if (up_ev && !dn_ev && volume != 5'd31) vol_d = volume + 5'd1;
    else if (dn_ev && !up_ev && volume != 5'd0) vol_d = volume - 5'd1;
    // Out-of-range sources (only possible from SRC_RESET) also wrap to 0.
    if (src_ev) src_d = (source >= 3'(SRC_MAX)) ? 3'd0 : source + 3'd1;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      volume  <= 5'(VOL_RESET);
      source  <= 3'(SRC_RESET);
      changed <= 1'b0;
    end else begin
      volume  <= vol_d;
      source  <= src_d;
      changed <= (vol_d != volume) || (src_d != source);
    end
  end

endmodule

// File: tb/tb_ac97_user_ctrl.sv
// Self-checking bench for ac97_user_ctrl: two instances (VOL_RESET 20 and 30)
// share stimulus and are compared against a press-level behavioural model.
module tb_ac97_user_ctrl;

  localparam int DEB      = 4;
  localparam int RPT_DLY  = 10;
  localparam int RPT_RATE = 5;
  localparam int GAP      = DEB + 8;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       ac97_ready = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_src = 1'b0;
  logic [4:0] volume, volume_hi;
  logic [2:0] source, source_hi;
  logic       changed, changed_hi;

  ac97_user_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .VOL_RESET(20), .SRC_RESET(0), .SRC_MAX(4),
    .REPEAT_DELAY(RPT_DLY), .REPEAT_RATE(RPT_RATE)
  ) u_dut (
    .clk(clk), .n_reset(n_reset), .ac97_ready(ac97_ready),
    .btn_up(btn_up), .btn_down(btn_down), .btn_src(btn_src),
    .volume(volume), .source(source), .changed(changed)
  );

  ac97_user_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .VOL_RESET(30), .SRC_RESET(0), .SRC_MAX(4),
    .REPEAT_DELAY(RPT_DLY), .REPEAT_RATE(RPT_RATE)
  ) u_dut_hi (
    .clk(clk), .n_reset(n_reset), .ac97_ready(ac97_ready),
    .btn_up(btn_up), .btn_down(btn_down), .btn_src(btn_src),
    .volume(volume_hi), .source(source_hi), .changed(changed_hi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int chg_hi_n = 0;
  int chg_times[$];
  int errors = 0;
  int checks = 0;

  // Reference model state: one volume per instance, shared source.
  int m_vol, m_vol_hi, m_src;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (n_reset && changed) chg_times.push_back(cyc);
    if (n_reset && changed_hi) chg_hi_n <= chg_hi_n + 1;
  end

  function automatic int vol_step(input int v, input bit u, input bit d);
    if (u && !d) return (v < 31) ? v + 1 : 31;
    if (d && !u) return (v > 0) ? v - 1 : 0;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_vol    = 20;
    m_vol_hi = 30;
    m_src    = 0;
  endtask

  // One clean press of the selected buttons; returns the expected change counts.
  task automatic press(input bit u, input bit d, input bit s, input int hold,
                       output int exp_chg, output int exp_chg_hi);
    int ov, ovh, os;
    ov = m_vol; ovh = m_vol_hi; os = m_src;
    if (ac97_ready) begin
      m_vol    = vol_step(m_vol, u, d);
      m_vol_hi = vol_step(m_vol_hi, u, d);
      if (s) m_src = (m_src >= 4) ? 0 : m_src + 1;
    end
    exp_chg    = (m_vol != ov || m_src != os) ? 1 : 0;
    exp_chg_hi = (m_vol_hi != ovh || m_src != os) ? 1 : 0;
    btn_up = u; btn_down = d; btn_src = s;
    tick(hold);
    btn_up = 1'b0; btn_down = 1'b0; btn_src = 1'b0;
    tick(GAP);
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    tick(3);
    model_reset();
    n_reset = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    int base;
    n_reset = 1'b0;
    ac97_ready = 1'b1;
    tick(3);
    model_reset();
    checks++;
    if (volume !== 5'd20 || source !== 3'd0 || changed !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: vol=%0d src=%0d chg=%0b, want 20 0 0", volume, source, changed);
    end
    n_reset = 1'b1;
    base = chg_times.size();
    tick(100);
    checks++;
    if (volume !== 5'd20 || source !== 3'd0 || volume_hi !== 5'd30) begin
      errors++;
      $display("FAIL reset_idle: vol=%0d src=%0d vol_hi=%0d, want 20 0 30", volume, source, volume_hi);
    end
    checks++;
    if (chg_times.size() != base || changed !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_changed: pulses=%0d, want 0", chg_times.size() - base);
    end
  endtask

  task automatic test_debounce();
    int base, c0, ec, ech, hold;
`ifdef AUTO_REPEAT_EN
    hold = 8;
`else
    hold = 20;
`endif
    base = chg_times.size();
    c0 = cyc;
    press(1, 0, 0, hold, ec, ech);
    checks++;
    if (volume !== 5'(m_vol) || m_vol != 21) begin
      errors++;
      $display("FAIL deb_press_vol: got %0d want 21", volume);
    end
    checks++;
    if (chg_times.size() - base != 1) begin
      errors++;
      $display("FAIL deb_press_pulses: got %0d want 1", chg_times.size() - base);
    end else begin
      checks++;
      if (chg_times[base] != c0 + DEB + 3) begin
        errors++;
        $display("FAIL deb_latency: changed at cycle %0d want %0d", chg_times[base], c0 + DEB + 3);
      end
    end
    // A glitch one cycle shorter than the debounce window is ignored.
    base = chg_times.size();
    btn_up = 1'b1;
    tick(DEB - 1);
    btn_up = 1'b0;
    tick(GAP);
    checks++;
    if (volume !== 5'(m_vol) || chg_times.size() != base) begin
      errors++;
      $display("FAIL deb_glitch: vol=%0d pulses=%0d want %0d 0", volume, chg_times.size() - base, m_vol);
    end
    // Exactly the debounce window is accepted.
    base = chg_times.size();
    press(1, 0, 0, DEB, ec, ech);
    checks++;
    if (volume !== 5'(m_vol) || chg_times.size() - base != ec) begin
      errors++;
      $display("FAIL deb_min_width: vol=%0d pulses=%0d want %0d %0d", volume, chg_times.size() - base, m_vol, ec);
    end
  endtask

  task automatic test_saturate();
    int base_hi, ec, ech;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      base_hi = chg_hi_n;
      press(1, 0, 0, 6, ec, ech);
      checks++;
      if (volume_hi !== 5'd31 || volume !== 5'(21 + i)) begin
        errors++;
        $display("FAIL sat_vol[%0d]: hi=%0d lo=%0d want 31 %0d", i, volume_hi, volume, 21 + i);
      end
      checks++;
      if (chg_hi_n - base_hi != ((i == 0) ? 1 : 0)) begin
        errors++;
        $display("FAIL sat_changed[%0d]: got %0d want %0d", i, chg_hi_n - base_hi, (i == 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_src_wrap();
    int base, ec, ech, want;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      base = chg_times.size();
      want = (i + 1) % 5;
      press(0, 0, 1, 6, ec, ech);
      checks++;
      if (source !== 3'(want) || chg_times.size() - base != 1) begin
        errors++;
        $display("FAIL src_wrap[%0d]: src=%0d pulses=%0d want %0d 1", i, source, chg_times.size() - base, want);
      end
    end
  endtask

  task automatic test_simultaneous();
    int base, ec, ech;
    base = chg_times.size();
    press(1, 1, 0, 6, ec, ech);
    checks++;
    if (volume !== 5'(m_vol) || chg_times.size() != base) begin
      errors++;
      $display("FAIL updown_cancel: vol=%0d pulses=%0d want %0d 0", volume, chg_times.size() - base, m_vol);
    end
    base = chg_times.size();
    press(1, 0, 1, 6, ec, ech);
    checks++;
    if (volume !== 5'(m_vol) || source !== 3'(m_src) || chg_times.size() - base != 1) begin
      errors++;
      $display("FAIL src_and_up: vol=%0d src=%0d pulses=%0d want %0d %0d 1",
               volume, source, chg_times.size() - base, m_vol, m_src);
    end
  endtask

  task automatic test_not_ready();
    int base, ec, ech;
    base = chg_times.size();
    ac97_ready = 1'b0;
    press(1, 0, 1, 6, ec, ech);
    ac97_ready = 1'b1;
    tick(GAP);
    checks++;
    if (volume !== 5'(m_vol) || source !== 3'(m_src) || chg_times.size() != base) begin
      errors++;
      $display("FAIL not_ready: vol=%0d src=%0d pulses=%0d want %0d %0d 0",
               volume, source, chg_times.size() - base, m_vol, m_src);
    end
  endtask

  task automatic test_reset_mid();
    btn_up = 1'b1;
    tick(3);
    n_reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (volume !== 5'd20 || source !== 3'd0 || volume_hi !== 5'd30 || changed !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: vol=%0d src=%0d hi=%0d chg=%0b want 20 0 30 0", volume, source, volume_hi, changed);
    end
    btn_up = 1'b0;
    tick(2);
    n_reset = 1'b1;
    tick(GAP);
    checks++;
    if (volume !== 5'd20 || source !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_after: vol=%0d src=%0d want 20 0", volume, source);
    end
  endtask

  task automatic test_random();
    int base, base_hi, ec, ech;
    bit u, d, s, rdy;
    for (int i = 0; i < 40; i++) begin
      u = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 3) != 0);
      base = chg_times.size();
      base_hi = chg_hi_n;
      ac97_ready = rdy;
      press(u, d, s, DEB + 1 + int'($urandom_range(0, 4)), ec, ech);
      ac97_ready = 1'b1;
      checks++;
      if (volume !== 5'(m_vol) || volume_hi !== 5'(m_vol_hi) || source !== 3'(m_src) || source_hi !== 3'(m_src)) begin
        errors++;
        $display("FAIL rand_state[%0d]: vol=%0d hi=%0d src=%0d want %0d %0d %0d",
                 i, volume, volume_hi, source, m_vol, m_vol_hi, m_src);
      end
      checks++;
      if (chg_times.size() - base != ec || chg_hi_n - base_hi != ech) begin
        errors++;
        $display("FAIL rand_changed[%0d]: got %0d/%0d want %0d/%0d",
                 i, chg_times.size() - base, chg_hi_n - base_hi, ec, ech);
      end
    end
  endtask

`ifdef AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    int base, c0, hold;
    int exp_t[$];
    int t;
    do_reset();
    hold = 40;
    // Events land at 0, DELAY, DELAY+RATE, ... after the press while held.
    t = 0;
    exp_t.push_back(0);
    t = RPT_DLY;
    while (t < hold) begin
      exp_t.push_back(t);
      t += RPT_RATE;
    end
    base = chg_times.size();
    c0 = cyc;
    btn_down = 1'b1;
    tick(hold);
    btn_down = 1'b0;
    tick(GAP + RPT_DLY);
    foreach (exp_t[k]) begin
      m_vol    = vol_step(m_vol, 0, 1);
      m_vol_hi = vol_step(m_vol_hi, 0, 1);
    end
    checks++;
    if (chg_times.size() - base != exp_t.size()) begin
      errors++;
      $display("FAIL rpt_count: got %0d want %0d", chg_times.size() - base, exp_t.size());
    end else begin
      foreach (exp_t[k]) begin
        checks++;
        if (chg_times[base + k] != c0 + DEB + 3 + exp_t[k]) begin
          errors++;
          $display("FAIL rpt_time[%0d]: cycle %0d want %0d", k, chg_times[base + k], c0 + DEB + 3 + exp_t[k]);
        end
      end
    end
    checks++;
    if (volume !== 5'(m_vol) || volume_hi !== 5'(m_vol_hi)) begin
      errors++;
      $display("FAIL rpt_final: vol=%0d hi=%0d want %0d %0d", volume, volume_hi, m_vol, m_vol_hi);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_debounce();
    test_saturate();
    test_src_wrap();
    test_simultaneous();
    test_not_ready();
    test_reset_mid();
    test_random();
`ifdef AUTO_REPEAT_EN
    test_auto_repeat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
